// File: rtl/fetch_queue_pkg.sv
// Shared widths, constants and entry layout for the fetch queue.
package fetch_queue_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int ADDRESS_WIDTH     = 32;
  localparam int ENTRY_WIDTH       = ADDRESS_WIDTH + INSTRUCTION_WIDTH;
  localparam int DEFAULT_DEPTH     = 4;

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0000;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0]     pc;
    logic [INSTRUCTION_WIDTH-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue: one synchronous write port, one asynchronous read port.
module queue_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 wr_en_i,
  input  logic [PTR_WIDTH-1:0] wr_addr_i,
  input  fq_entry_t            wr_data_i,
  input  logic [PTR_WIDTH-1:0] rd_addr_i,
  output fq_entry_t            rd_data_o
);

  fq_entry_t mem_q [DEPTH];

  // No reset on the array; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction fetch and decode; first-word-fall-through with flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDRESS_WIDTH-1:0]     if_program_counter,
  input  logic                         if_chip_enable,
  input  logic [INSTRUCTION_WIDTH-1:0] rom_instruction,
  input  logic                         flush,
  output logic                         if_stall,
  input  logic                         id_ready,
  output logic                         id_valid,
  output logic [ADDRESS_WIDTH-1:0]     id_program_counter,
  output logic [INSTRUCTION_WIDTH-1:0] id_instruction,
  output logic [PTR_WIDTH:0]           count
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 full, push, pop;
  fq_entry_t            wr_entry, head_entry;

  assign full = (count_q == FULL_COUNT);

  // Outputs are masked while reset is held so nothing stale leaks to decode.
  assign id_valid = (count_q != '0) && !reset;
  assign if_stall = full && !reset;
  assign count    = reset ? '0 : count_q;

  assign push = if_chip_enable && !full && !flush;
  assign pop  = id_valid && id_ready && !flush;

  assign wr_entry.pc    = if_program_counter;
  assign wr_entry.instr = rom_instruction;

  queue_storage #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_storage (
    .clock     (clock),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_entry)
  );

  assign id_program_counter = id_valid ? head_entry.pc    : '0;
  assign id_instruction     = id_valid ? head_entry.instr : NOP_INSTRUCTION;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, fill/stall, push+pop, flush, wrap, mid-stream reset.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_program_counter;
  logic        if_chip_enable;
  logic [31:0] rom_instruction;
  logic        flush;
  logic        if_stall;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_program_counter;
  logic [31:0] id_instruction;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_queue dut (
    .clock              (clock),
    .reset              (reset),
    .if_program_counter (if_program_counter),
    .if_chip_enable     (if_chip_enable),
    .rom_instruction    (rom_instruction),
    .flush              (flush),
    .if_stall           (if_stall),
    .id_ready           (id_ready),
    .id_valid           (id_valid),
    .id_program_counter (id_program_counter),
    .id_instruction     (id_instruction),
    .count              (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic ce, input logic [31:0] pc, input logic [31:0] ins);
    if_chip_enable     = ce;
    if_program_counter = pc;
    rom_instruction    = ins;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [2:0] cnt);
    check({tag, "_valid"}, 32'(id_valid), 32'(v));
    check({tag, "_pc"},    id_program_counter, pc);
    check({tag, "_instr"}, id_instruction, ins);
    check({tag, "_count"}, 32'(count), 32'(cnt));
  endtask

  logic [31:0] mq_pc[$];
  logic [15:0] ready_pat = 16'b1011_0010_0111_0001;
  int          sent, recvd;
  logic        do_push, do_pop;
  logic [31:0] cur_pc;

  initial begin
    reset = 1'b1; flush = 1'b0; id_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);

    // Reset then idle
    tick();
    check_head("reset", 1'b0, 32'h0, 32'h0, 3'd0);
    check("reset_stall", 32'(if_stall), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check_head("idle", 1'b0, 32'h0, 32'h0, 3'd0);
    check("idle_stall", 32'(if_stall), 32'h0);

    // Streaming with decode always ready
    id_ready = 1'b1;
    offer(1'b1, 32'h0, 32'h2001_0001);
    tick();
    check_head("stream0", 1'b1, 32'h0, 32'h2001_0001, 3'd1);
    offer(1'b1, 32'h4, 32'h2002_0002);
    tick();
    check_head("stream1", 1'b1, 32'h4, 32'h2002_0002, 3'd1);
    offer(1'b1, 32'h8, 32'h2003_0003);
    tick();
    check_head("stream2", 1'b1, 32'h8, 32'h2003_0003, 3'd1);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check_head("stream_empty", 1'b0, 32'h0, 32'h0, 3'd0);

    // Fill to full; fifth word dropped
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i * 4));
      tick();
    end
    offer(1'b0, 32'h0, 32'h0);
    check_head("full", 1'b1, 32'h0, 32'hA000_0000, 3'd4);
    check("full_stall", 32'(if_stall), 32'h1);
    id_ready = 1'b1;
    tick();
    check_head("drain1", 1'b1, 32'h4, 32'hA000_0004, 3'd3);
    check("drain1_stall", 32'(if_stall), 32'h0);
    tick();
    check_head("drain2", 1'b1, 32'h8, 32'hA000_0008, 3'd2);
    tick();
    check_head("drain3", 1'b1, 32'hC, 32'hA000_000C, 3'd1);
    tick();
    check_head("drain4", 1'b0, 32'h0, 32'h0, 3'd0);

    // Simultaneous push and pop at count 2
    id_ready = 1'b0;
    offer(1'b1, 32'h40, 32'hB000_0040);
    tick();
    offer(1'b1, 32'h44, 32'hB000_0044);
    tick();
    check_head("pp_pre", 1'b1, 32'h40, 32'hB000_0040, 3'd2);
    offer(1'b1, 32'h48, 32'hB000_0048);
    id_ready = 1'b1;
    tick();
    check_head("pp_both", 1'b1, 32'h44, 32'hB000_0044, 3'd2);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check_head("pp_tail", 1'b1, 32'h48, 32'hB000_0048, 3'd1);
    tick();
    check_head("pp_empty", 1'b0, 32'h0, 32'h0, 3'd0);

    // Flush while full, with a push and a pop offered in the same cycle
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h50 + 32'(i * 4), 32'hC000_0000 + 32'(i));
      tick();
    end
    check("pre_flush_stall", 32'(if_stall), 32'h1);
    flush = 1'b1; id_ready = 1'b1;
    offer(1'b1, 32'h60, 32'hC000_0060);
    tick();
    check_head("flush", 1'b0, 32'h0, 32'h0, 3'd0);
    check("flush_stall", 32'(if_stall), 32'h0);
    flush = 1'b0; id_ready = 1'b0;
    offer(1'b1, 32'h100, 32'hD000_0100);
    tick();
    check_head("post_flush", 1'b1, 32'h100, 32'hD000_0100, 3'd1);
    offer(1'b0, 32'h0, 32'h0);
    id_ready = 1'b1;
    tick();
    check_head("post_flush_pop", 1'b0, 32'h0, 32'h0, 3'd0);

    // Ten words across pointer wrap with irregular decode readiness
    sent = 0; recvd = 0;
    for (int cyc = 0; cyc < 80 && recvd < 10; cyc++) begin
      cur_pc = 32'h200 + 32'(sent * 4);
      offer(sent < 10, cur_pc, cur_pc ^ 32'h5A5A_0000);
      id_ready = ready_pat[cyc % 16];
      check("wrap_stall", 32'(if_stall), 32'(mq_pc.size() == 4));
      do_push = (sent < 10) && (mq_pc.size() < 4);
      do_pop  = (mq_pc.size() != 0) && id_ready;
      tick();
      if (do_pop) begin
        void'(mq_pc.pop_front());
        recvd++;
      end
      if (do_push) begin
        mq_pc.push_back(cur_pc);
        sent++;
      end
      if (mq_pc.size() != 0)
        check_head("wrap", 1'b1, mq_pc[0], mq_pc[0] ^ 32'h5A5A_0000, 3'(mq_pc.size()));
      else
        check_head("wrap", 1'b0, 32'h0, 32'h0, 3'd0);
    end
    check("wrap_received", 32'(recvd), 32'd10);
    offer(1'b0, 32'h0, 32'h0);
    id_ready = 1'b0;

    // Reset asserted mid-stream empties the queue at that edge
    offer(1'b1, 32'h300, 32'hE000_0300);
    tick();
    offer(1'b1, 32'h304, 32'hE000_0304);
    tick();
    check_head("pre_reset", 1'b1, 32'h300, 32'hE000_0300, 3'd2);
    reset = 1'b1;
    offer(1'b1, 32'h308, 32'hE000_0308);
    tick();
    check_head("mid_reset", 1'b0, 32'h0, 32'h0, 3'd0);
    reset = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check_head("after_reset", 1'b0, 32'h0, 32'h0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Prefetch buffer directly downstream of the instruction-fetch stage. Captures each (program_counter, instruction) pair produced by fetch and the instruction ROM, and presents them in order to the decode stage.
- Decouples a stalled decode from fetch with small FIFO storage.
- Drops all buffered entries on a branch/jump flush.
- Back-pressures fetch when full.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_WIDTH, 2, log2(DEPTH); width of read/write pointers.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- if_program_counter  input  32  PC of the word currently fetched.
- if_chip_enable  input  1  fetch valid; the pair on the if_* / rom_* inputs is offered this cycle.
- rom_instruction  input  32  instruction word read from ROM at if_program_counter.
- flush  input  1  branch/jump redirect; discards all entries.
- if_stall  output  1  queue full; fetch must hold its PC.
- id_ready  input  1  decode accepts the head entry this cycle.
- id_valid  output  1  head entry is valid.
- id_program_counter  output  32  PC of the head entry.
- id_instruction  output  32  instruction of the head entry; NOP when empty.
- count  output  PTR_WIDTH+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (synchronous, active-high) clears rd_ptr, wr_ptr and count to 0. Storage contents are don't-care.
- Outputs during and after reset: id_valid=0, id_instruction=32'h0, id_program_counter=0, if_stall=0, count=0.
- Push condition: if_chip_enable=1 and count<DEPTH and flush=0.
  - Entry written at wr_ptr; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop condition: id_valid=1 and id_ready=1 and flush=0.
  - rd_ptr increments with the same wrap.
- count update per cycle: +1 for push only, -1 for pop only, unchanged for both or neither.
- First-word-fall-through: id_* show storage[rd_ptr] combinationally from registered pointers.
  - id_valid = (count != 0).
  - A word pushed at edge N is visible on id_* in cycle N+1; one-cycle latency.
- Empty queue:
  - id_instruction = 32'h0 (NOP), id_program_counter = 0, id_valid = 0.
  - id_ready is ignored; no underflow.
- Full queue (count == DEPTH):
  - if_stall = 1, decoded from registered count only; no combinational path from id_ready.
  - A push offered while full is dropped even if a pop occurs the same cycle.
  - Fetch is required to hold its PC while if_stall = 1.
- Flush:
  - At the next edge, rd_ptr = wr_ptr = 0 and count = 0.
  - Overrides any simultaneous push or pop; the word offered in the flush cycle is discarded.
  - if_stall drops to 0 the cycle after the flush.
- Reset has priority over flush. Reset asserted mid-operation empties the queue identically to a flush and also forces all outputs to their reset values.
- Pointer wrap: pointers are PTR_WIDTH bits and wrap naturally; full/empty are distinguished by count, never by pointer equality.
- No X propagation: id_* are driven to the NOP/zero values whenever id_valid = 0.

Decomposition:
- Shared package/header:
  - INSTRUCTION_WIDTH = 32
  - ADDRESS_WIDTH = 32
  - NOP_INSTRUCTION = 32'h0000_0000
  - default queue depth constant
- One natural sub-module: queue_storage.
  - DEPTH x 64-bit register array.
  - One synchronous write port (wr_en, wr_addr, wr_data).
  - One asynchronous read port (rd_addr -> rd_data).
- Pointer, count, stall and flush control stay in fetch_queue.

Test Plan:
- Reset then idle: hold reset 2 cycles, release with if_chip_enable=0 -> id_valid=0, id_instruction=0, if_stall=0, count=0.
- Streaming: id_ready=1, push PCs 0,4,8 with words 32'h20010001, 32'h20020002, 32'h20030003 -> id_* show each pair one cycle after push; count stays at most 1; order preserved.
- Fill and stall: id_ready=0, push 5 words at PC 0..16 -> count reaches 4, if_stall=1 after the 4th push, and PC 16 is dropped. Then id_ready=1 for 4 cycles -> PCs 0,4,8,12 pop in order, and if_stall clears the cycle after the first pop.
- Simultaneous push/pop at count=2 -> count stays 2, head advances to the next PC, new word enqueued at the tail.
- Flush while full and pushing -> next cycle count=0, id_valid=0, if_stall=0. The next push (PC 32'h100) appears at the head one cycle later.
- Pointer wrap: push/pop 10 words with varying id_ready gaps -> all 10 emerge in order across pointer wrap, with no duplicates or losses. Reset asserted mid-stream -> queue empties at that edge.
